// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: drives PC enable and the en/flush pair of every pipeline register.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_muldiv,
    input  logic       ex_redirect,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       if_id_flush,
    output logic       id_ex_en,
    output logic       id_ex_flush,
    output logic       ex_mem_en,
    output logic       ex_mem_flush,
    output logic       mem_wb_en,
    output logic       mem_wb_flush,
    output logic       muldiv_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_MULDIV = 1'b1;

    localparam logic             MD_ENABLED = (MULDIV_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(MULDIV_LAT - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mem_stall;
    logic load_use;
    logic md_stall;

    always_comb begin
        mem_stall = mem_req & ~mem_ready;
        load_use  = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));
        md_stall  = ((state_q == ST_RUN) & ex_muldiv & MD_ENABLED) |
                    ((state_q == ST_MULDIV) & (cnt_q > CNT_ONE));
    end

    // A mem-stalled cycle freezes the occupancy sequence so it never counts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!mem_stall) begin
            if (state_q == ST_RUN) begin
                if (ex_muldiv && MD_ENABLED) begin
                    state_d = ST_MULDIV;
                    cnt_d   = CNT_LOAD;
                end
            end else begin
                if (cnt_q > CNT_ONE) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Redirect outranks load-use because the ID instruction is on the wrong path.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        ex_mem_flush = 1'b0;
        mem_wb_en    = 1'b1;
        mem_wb_flush = 1'b0;
        if (mem_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (md_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
        muldiv_busy = (state_q == ST_MULDIV);
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, ~pc_en};
        flush_cnt_d = flush_cnt_q + {31'd0, (if_id_flush | id_ex_flush)};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Default build: no performance counters.
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (MULDIV_LAT=4).
// Honours HAZARD_PERF_CNT_EN so the same file checks both builds.
module tb_hazard_stall_ctrl;

    logic       CLK;
    logic       RST;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_muldiv;
    logic       ex_redirect;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_flush;
    logic       ex_mem_en;
    logic       ex_mem_flush;
    logic       mem_wb_en;
    logic       mem_wb_flush;
    logic       muldiv_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    hazard_stall_ctrl #(.MULDIV_LAT(4), .CNT_W(4)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_muldiv    (ex_muldiv),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_en     (id_ex_en),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_en    (ex_mem_en),
        .ex_mem_flush (ex_mem_flush),
        .mem_wb_en    (mem_wb_en),
        .mem_wb_flush (mem_wb_flush),
        .muldiv_busy  (muldiv_busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Output bundle, MSB first: pc, if_id en/fl, id_ex en/fl, ex_mem en/fl, mem_wb en/fl, busy.
    logic [31:0] outVec;
    assign outVec = {22'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                     ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, muldiv_busy};

    function automatic logic [31:0] makeVec(input logic pc, input logic ie, input logic ifl,
                                            input logic de, input logic dfl, input logic xe,
                                            input logic xfl, input logic we, input logic wfl,
                                            input logic busy);
        return {22'd0, pc, ie, ifl, de, dfl, xe, xfl, we, wfl, busy};
    endfunction

    function automatic logic [31:0] vIdle(input logic busy);
        return makeVec(1, 1, 0, 1, 0, 1, 0, 1, 0, busy);
    endfunction
    function automatic logic [31:0] vLoadUse();
        return makeVec(0, 0, 0, 1, 1, 1, 0, 1, 0, 0);
    endfunction
    function automatic logic [31:0] vMulDiv(input logic busy);
        return makeVec(0, 0, 0, 0, 0, 1, 1, 1, 0, busy);
    endfunction
    function automatic logic [31:0] vRedirect();
        return makeVec(1, 1, 1, 1, 1, 1, 0, 1, 0, 0);
    endfunction
    function automatic logic [31:0] vMemStall(input logic busy);
        return makeVec(0, 0, 0, 0, 0, 0, 0, 0, 1, busy);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's inputs just after the falling edge, then settles before sampling.
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic mrd, input logic md, input logic rdr,
                                 input logic mq, input logic mrdy);
        @(negedge CLK);
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
        ex_rd       = rd;
        ex_mem_read = mrd;
        ex_muldiv   = md;
        ex_redirect = rdr;
        mem_req     = mq;
        mem_ready   = mrdy;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        RST         = 1'b0;
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        id_uses_rs1 = 1'b0;
        id_uses_rs2 = 1'b0;
        ex_rd       = 5'd0;
        ex_mem_read = 1'b0;
        ex_muldiv   = 1'b0;
        ex_redirect = 1'b0;
        mem_req     = 1'b0;
        mem_ready   = 1'b0;
        #1;
        checkOutput("reset_outputs", outVec, vIdle(0));
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("reset_stall_cnt", stall_cnt, 32'd0);
        checkOutput("reset_flush_cnt", flush_cnt, 32'd0);
`endif
        @(negedge CLK);
        RST = 1'b1;
        idleCycle();
        checkOutput("idle_after_reset", outVec, vIdle(0));

        // Load-use detection on rs1, rs2, x0 and unused-operand cases.
        applyStimulus(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, 0);
        checkOutput("load_use_rs1", outVec, vLoadUse());
        applyStimulus(5'd1, 5'd9, 1, 1, 5'd9, 1, 0, 0, 0, 0);
        checkOutput("load_use_rs2", outVec, vLoadUse());
        applyStimulus(5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, 0);
        checkOutput("load_use_x0", outVec, vIdle(0));
        applyStimulus(5'd5, 5'd0, 0, 0, 5'd5, 1, 0, 0, 0, 0);
        checkOutput("load_use_unused", outVec, vIdle(0));
        applyStimulus(5'd5, 5'd0, 1, 0, 5'd5, 0, 0, 0, 0, 0);
        checkOutput("no_load_no_stall", outVec, vIdle(0));

        // Plain MUL/DIV occupancy: stall T0..T2, release T3.
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0);
        checkOutput("md_t0", outVec, vMulDiv(0));
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0);
        checkOutput("md_t1", outVec, vMulDiv(1));
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0);
        checkOutput("md_t2", outVec, vMulDiv(1));
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0);
        checkOutput("md_t3_release", outVec, vIdle(1));
        idleCycle();
        checkOutput("md_after", outVec, vIdle(0));

        // MUL/DIV with a 3-cycle memory wait at T1: release slips to T6.
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0);
        checkOutput("mdw_t0", outVec, vMulDiv(0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1, 0);
            checkOutput($sformatf("mdw_memstall_%0d", i), outVec, vMemStall(1));
        end
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0);
        checkOutput("mdw_t4", outVec, vMulDiv(1));
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0);
        checkOutput("mdw_t5", outVec, vMulDiv(1));
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0);
        checkOutput("mdw_t6_release", outVec, vIdle(1));
        idleCycle();
        checkOutput("mdw_after", outVec, vIdle(0));

        // Redirect beats load-use.
        applyStimulus(5'd7, 5'd0, 1, 0, 5'd7, 1, 0, 1, 0, 0);
        checkOutput("redirect_over_load_use", outVec, vRedirect());

        // Redirect held through a memory wait, acted on once memory is ready.
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0);
        checkOutput("redirect_in_memstall", outVec, vMemStall(0));
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 1);
        checkOutput("redirect_mem_ready", outVec, vRedirect());

        // Redirect alongside a MUL/DIV start: the occupancy stall wins.
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 0);
        checkOutput("md_over_redirect", outVec, vMulDiv(0));
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0);
        checkOutput("ar_t1", outVec, vMulDiv(1));
        // Now in MULDIV with cnt=2; ex_muldiv dropping must not matter there.
        applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        checkOutput("ar_cnt2_ignores_muldiv", outVec, vMulDiv(1));
        #1;
        RST = 1'b0;
        #1;
        checkOutput("async_reset_mid_md", outVec, vIdle(0));
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("async_reset_stall_cnt", stall_cnt, 32'd0);
        checkOutput("async_reset_flush_cnt", flush_cnt, 32'd0);
`endif
        @(negedge CLK);
        RST = 1'b1;
        idleCycle();
        checkOutput("idle_after_async_reset", outVec, vIdle(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central hazard/stall controller that drives the en and Flush inputs of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB), plus the PC enable, in the 5-stage RISC-V core.
- Resolves four hazard sources:
  - load-use
  - taken-branch/jump redirect
  - multi-cycle MUL/DIV occupancy of EX
  - data-memory wait handshake
- Holds a small FSM and a latency counter for the MUL/DIV occupancy.

Parameters:
- MULDIV_LAT, default 4: cycles a MUL/DIV op occupies EX. Legal range 1..15; a value of 1 means no stall.
- CNT_W, default 4: width of the occupancy counter. Must satisfy 2^CNT_W > MULDIV_LAT.

Ports:
- CLK  in  1  single core clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- id_rs1  in  5  rs1 index of the instruction in ID.
- id_rs2  in  5  rs2 index of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_muldiv  in  1  instruction in EX is MUL/DIV.
- ex_redirect  in  1  EX resolved a taken branch/jump (PC redirect).
- mem_req  in  1  instruction in MEM accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- if_id_en, if_id_flush  out  1 each.
- id_ex_en, id_ex_flush  out  1 each.
- ex_mem_en, ex_mem_flush  out  1 each.
- mem_wb_en, mem_wb_flush  out  1 each.
- muldiv_busy  out  1  FSM in MULDIV state (debug/status).

Behaviour:
- Reset: one clock CLK; reset RST is asynchronous, active-low.
  - RST=0 forces state=RUN and cnt=0 immediately.
  - Outputs are combinational from state and inputs. With idle inputs during and after reset: all *_en=1, all *_flush=0, muldiv_busy=0.
- Derived hazard terms, all combinational:
  - mem_stall = mem_req & ~mem_ready.
  - load_use = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - md_stall = (state==RUN & ex_muldiv & MULDIV_LAT>1) | (state==MULDIV & cnt>1).
- Priority, highest first; exactly one row applies per cycle:
  1. mem_stall: all *_en=0. mem_wb_flush=1 (bubble into WB). All other flushes=0; redirect and load-use flushes are suppressed, and EX simply holds ex_redirect.
  2. md_stall: pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1; all other en=1.
  3. ex_redirect: if_id_flush=id_ex_flush=1; all en=1. Redirect wins over load_use because the ID instruction is wrong-path.
  4. load_use: pc_en=if_id_en=0, id_ex_flush=1. Exactly 1 bubble cycle.
  5. Otherwise: all en=1, all flush=0.
- FSM (states RUN, MULDIV), 4-bit cnt:
  - RUN & ex_muldiv & ~mem_stall & MULDIV_LAT>1: cnt<=MULDIV_LAT-1, go to MULDIV.
  - MULDIV & ~mem_stall & cnt>1: cnt<=cnt-1.
  - MULDIV & ~mem_stall & cnt==1: release (md_stall=0), cnt<=0, go to RUN.
  - mem_stall in either state: state and cnt frozen; the cycle does not count.
  - Net result: a MUL/DIV op is resident in EX for exactly MULDIV_LAT non-mem-stalled cycles. The front end is stalled for the first MULDIV_LAT-1 of them.
  - ex_muldiv remains high while the op is held; it is ignored in MULDIV. A new ex_muldiv in the cycle after release starts a fresh sequence.
- ex_redirect cannot coincide with md_stall (EX holds the MUL/DIV op). If both are asserted anyway, md_stall wins; the redirect is acted on at release.
- Reset mid-MULDIV: immediate return to RUN, cnt=0, stalls drop asynchronously.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0], both reset to 0 and wrapping modulo 2^32.
  - stall_cnt increments every cycle pc_en==0.
  - flush_cnt increments every cycle if_id_flush|id_ex_flush is 1.
- Undefined: neither the ports nor the logic exist; behaviour is otherwise identical.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle only. With ex_rd=0 -> no stall.
2. MUL/DIV, MULDIV_LAT=4: ex_muldiv=1 at T0 -> md_stall at T0,T1,T2 with ex_mem_flush=1; release at T3 with all en=1; muldiv_busy=1 for T1..T3.
3. Mem wait mid-MULDIV: mem_req=1, mem_ready=0 for 3 cycles at T1 -> all en=0, mem_wb_flush=1, cnt frozen. Release occurs 3 cycles later than in scenario 2.
4. Redirect + load-use in the same cycle -> if_id_flush=id_ex_flush=1, pc_en=1, no load-use stall.
5. Redirect during mem_stall -> no flushes. When mem_ready=1 the next cycle, the flushes fire that cycle.
6. RST=0 asserted asynchronously while in MULDIV with cnt=2 -> muldiv_busy=0 and all en=1 without waiting for a CLK edge. HAZARD_PERF_CNT_EN build: counters read 0.
